mult4_shift_add: RTL
====================

Name: mult4_shift_add

Overview:
- Sequential 4x4 unsigned shift-and-add multiplier producing an 8-bit product.
- Sits directly around the team's 4-bit ripple-carry adder FA_4bit:
  - it prepares the partial-product operands that FA_4bit consumes each cycle;
  - it registers FA_4bit's sum/c_out back into an accumulator.
- Operands enter and the product leaves over valid/ready handshakes.
- One multiplier bit is processed per clock.

Parameters:
- WIDTH, 4, operand width. Only 4 is legal because it is tied to FA_4bit's width. Elaboration fails (generate-time error) otherwise.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands this cycle.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- out_valid  output  1  product valid; held until accepted.
- out_ready  input  1  consumer accepts product.
- product  output  2*WIDTH  a*b, unsigned.
- busy  output  1  high while in BUSY state.

Behaviour:
- Reset (rst_n low, asynchronous, immediate):
  - state=IDLE, out_valid=0, product=0, busy=0, internal counter=0, accumulator=0.
  - in_ready=1 while rst_n is high in IDLE.
- States are IDLE, BUSY and DONE.
- in_ready is combinational: in_ready = (state==IDLE) | (state==DONE & out_ready).
- Accept occurs when in_valid & in_ready at a rising edge. On accept:
  - mcand<=a; acc<={4'b0000,b}; count<=0; state<=BUSY.
- BUSY step, one per cycle:
  - FA_4bit inputs are a=acc[7:4], b=(acc[0] ? mcand : 4'b0000), c_in=0.
  - acc <= {c_out, sum, acc[3:1]}, i.e. a right shift with the adder carry entering bit 7.
  - count<=count+1.
  - When count==3 at the edge: state<=DONE, product<=next acc, out_valid<=1.
- Latency:
  - Operands accepted at edge N give out_valid=1 after edge N+4.
  - Latency is fixed at 4 cycles regardless of operand values; there is no zero-skip.
- DONE:
  - product and out_valid are held stable while out_ready=0 (stall of any length).
  - out_ready=1 at an edge with in_valid=0: out_valid<=0, state<=IDLE. product keeps its last value.
  - out_ready=1 at an edge with in_valid=1: the product is consumed and new operands are accepted at the same edge. out_valid<=0, state<=BUSY. This gives back-to-back throughput of one result per 5 cycles.
- in_valid is ignored in BUSY. Operands are never sampled except on accept.
- Width rules:
  - The adder carry is never dropped; the max product 15*15=225 fits in 8 bits.
  - The counter is 2 bits and wraps 3->0 on BUSY exit; its wrap value is unused.
- Reset mid-operation aborts immediately to the reset values.
  - No partial product is presented.
  - After reset release, the first accept proceeds normally.
- Output behaviour outside DONE:
  - out_valid never asserts outside DONE.
  - product changes only on the BUSY->DONE transition or on reset.

Decomposition:
- Shared package/include holds:
  - state encoding localparams: IDLE=2'd0, BUSY=2'd1, DONE=2'd2 (2'd3 is illegal and recovers to IDLE);
  - MULT_W=4 and PROD_W=8 constants, shared with the bench.
- One sub-module: FA_4bit, instantiated once as the datapath adder. It is itself built from FA_str instances.
- FSM, counter, accumulator and handshake logic are in mult4_shift_add. No other sub-modules.

Test Plan:
- Reset check: hold rst_n=0, then release -> in_ready=1, out_valid=0, product=8'h00, busy=0.
- Basic multiply: a=3, b=5, in_valid pulse, out_ready=1 -> out_valid exactly 4 cycles after accept, product=8'd15; busy high for 4 cycles.
- Carry path: a=15, b=15 -> product=8'd225 (8'hE1). Also a=0,b=9 -> 0 and a=9,b=0 -> 0; both still take 4 cycles.
- Output stall: a=7,b=6, out_ready=0 for 10 cycles after done -> product=8'd42 and out_valid=1 stable throughout; in_ready=0 throughout; a new in_valid is ignored.
- Back-to-back: hold in_valid=1 with (2,3) then (11,13), out_ready=1 -> products 6 then 143; second accept on the same edge the first result is consumed; results spaced 5 cycles apart.
- Reset mid-operation: accept a=12,b=10, drop rst_n at BUSY cycle 2 -> immediate out_valid=0, product=0. After release, a=4,b=4 -> product=16 with normal 4-cycle latency.
- Exhaustive sweep: all 256 (a,b) pairs with random out_ready stalls -> every product matches a*b, and the count of results equals the count of accepts.

Source files
------------

// File: rtl/mult4_shift_add_pkg.sv
// Shared constants and state encoding for the shift-and-add multiplier.
package mult4_shift_add_pkg;

    localparam int MULT_W = 4;
    localparam int PROD_W = 2 * MULT_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // 2'd3 is not a legal state; the FSM falls back to IDLE if it ever sees it.
    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        BUSY = ST_BUSY,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/mult4_shift_add_if.sv
// Operand/product handshake bundle for mult4_shift_add.
interface mult4_shift_add_if;
    import mult4_shift_add_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [MULT_W-1:0] a;
    logic [MULT_W-1:0] b;
    logic              out_valid;
    logic              out_ready;
    logic [PROD_W-1:0] product;
    logic              busy;

    // Producer/consumer side (drives operands, accepts products).
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    // Multiplier side.
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );

endinterface

// File: rtl/mult4_shift_add_fa4.sv
// 4-bit ripple-carry adder built from single-bit full adders.

// One full-adder cell.
module FA_str (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);
    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

// Four cells chained through the carry.
module FA_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);
    logic [4:0] carry;

    assign carry[0] = c_in;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        FA_str u_fa (
            .a     (a[i]),
            .b     (b[i]),
            .c_in  (carry[i]),
            .sum   (sum[i]),
            .c_out (carry[i+1])
        );
    end

    assign c_out = carry[4];
endmodule

// File: rtl/mult4_shift_add.sv
// Sequential 4x4 unsigned multiplier: one multiplier bit per clock through
// FA_4bit, fixed 4-cycle latency, valid/ready on both sides.
module mult4_shift_add
    import mult4_shift_add_pkg::*;
#(
    parameter int WIDTH = MULT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    mult4_shift_add_if.slave  bus
);

    // The datapath is hard-wired to the 4-bit adder.
    if (WIDTH != 4) begin : g_width_check
        $error("mult4_shift_add: WIDTH must be 4 (tied to FA_4bit)");
    end

    state_t             state;
    logic [1:0]         count;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] product;
    logic               out_valid;
    logic               busy;
    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   sum;
    logic               c_out;
    logic               accept;

    // Upper accumulator half plus the multiplicand when the current
    // multiplier bit (acc[0]) is set.
    assign add_b = acc[0] ? mcand : '0;

    FA_4bit u_add (
        .a     (acc[2*WIDTH-1:WIDTH]),
        .b     (add_b),
        .c_in  (1'b0),
        .sum   (sum),
        .c_out (c_out)
    );

    // Right shift with the adder carry landing in the MSB, so no bit is lost.
    assign acc_next = {c_out, sum, acc[WIDTH-1:1]};

    // A finished result may be swapped for new operands on the same edge.
    assign bus.in_ready = (state == IDLE) | ((state == DONE) & bus.out_ready);
    assign accept       = bus.in_valid & bus.in_ready;

    assign bus.product   = product;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;

    // Control FSM, counter, accumulator and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            mcand     <= '0;
            acc       <= '0;
            product   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcand <= bus.a;
                        acc   <= {{WIDTH{1'b0}}, bus.b};
                        count <= '0;
                        busy  <= 1'b1;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    acc   <= acc_next;
                    count <= count + 2'd1;
                    if (count == 2'd3) begin
                        product   <= acc_next;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        if (bus.in_valid) begin
                            mcand <= bus.a;
                            acc   <= {{WIDTH{1'b0}}, bus.b};
                            count <= '0;
                            busy  <= 1'b1;
                            state <= BUSY;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    count     <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
